rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine: optionally fills a single-port S-box RAM with the identity permutation, then runs the KSA swap loop over every S-box entry using a runtime-selectable key length. Sits between the key source and the S-box RAM in the decryption datapath and replaces the fixed-width, fixed-key-length shuffler. Uses a level start/busy/done handshake, so no external edge detector is needed.

---
 rtl/rc4_ksa_engine.sv | 211 +++++++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: runs the KSA swap loop over a single-port synchronous S-box RAM.
// Optional feature macro RC4_KSA_FILL_EN: the engine writes the identity permutation before the swap loop.
module rc4_ksa_engine #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 8,
    parameter int MAX_KEY_BYTES = 32,
    parameter int KLEN_W        = $clog2(MAX_KEY_BYTES + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [MAX_KEY_BYTES*DATA_W-1:0] key,
    input  logic [KLEN_W-1:0]               key_len,
    output logic                            busy,
    output logic                            done,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic [DATA_W-1:0]               ram_wdata,
    output logic                            ram_we,
    input  logic [DATA_W-1:0]               ram_rdata
);
    localparam int                 KIDX_W    = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
    localparam logic [KLEN_W-1:0]  MAX_LEN   = KLEN_W'(MAX_KEY_BYTES);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;

    typedef enum logic [3:0] {
        IDLE,
`ifdef RC4_KSA_FILL_EN
        FILL,
`endif
        RD_SI,
        WT_SI,
        CAP_SI,
        WT_SJ,
        CAP_SJ,
        WR_J,
        DONE_ST
    } state_t;

    state_t                          state, state_next;
    logic [ADDR_W-1:0]               i, i_next;
    logic [ADDR_W-1:0]               j, j_next;
    logic [ADDR_W-1:0]               si, si_next;
    logic [ADDR_W-1:0]               j_sum;
    logic [KIDX_W-1:0]               kidx, kidx_next;
    logic [KIDX_W-1:0]               kidx_last, kidx_last_next;
    logic [MAX_KEY_BYTES*DATA_W-1:0] key_reg, key_next;
    logic [KLEN_W-1:0]               eff_len;
    logic [DATA_W-1:0]               key_bytes [MAX_KEY_BYTES];
    logic [DATA_W-1:0]               key_byte;
    logic [ADDR_W-1:0]               addr_next;
    logic [DATA_W-1:0]               wdata_next;
    logic                            we_next;
    logic                            busy_next;
    logic                            done_next;
`ifdef RC4_KSA_FILL_EN
    logic [ADDR_W-1:0]               fcnt, fcnt_next;
    logic [ADDR_W-1:0]               fill_addr;
`endif

    // Byte 0 of the key sits in the most significant byte lane.
    always_comb begin
        for (int k = 0; k < MAX_KEY_BYTES; k++) begin
            key_bytes[k] = key_reg[(MAX_KEY_BYTES-1-k)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        eff_len = key_len;
        if (key_len == '0 || key_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    assign key_byte = key_bytes[kidx];
    assign j_sum    = j + ram_rdata[ADDR_W-1:0] + key_byte[ADDR_W-1:0];
`ifdef RC4_KSA_FILL_EN
    assign fill_addr = fcnt + ADDR_W'(1);
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        i_next         = i;
        j_next         = j;
        si_next        = si;
        kidx_next      = kidx;
        kidx_last_next = kidx_last;
        key_next       = key_reg;
        addr_next      = ram_addr;
        wdata_next     = ram_wdata;
        we_next        = 1'b0;
`ifdef RC4_KSA_FILL_EN
        fcnt_next      = fcnt;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    key_next       = key;
                    kidx_last_next = KIDX_W'(eff_len - KLEN_W'(1));
                    i_next         = '0;
                    j_next         = '0;
                    kidx_next      = '0;
`ifdef RC4_KSA_FILL_EN
                    fcnt_next      = '0;
                    addr_next      = '0;
                    wdata_next     = '0;
                    we_next        = 1'b1;
                    state_next     = FILL;
`else
                    state_next     = RD_SI;
`endif
                end
            end
`ifdef RC4_KSA_FILL_EN
            FILL: begin
                if (fcnt == LAST_ADDR) begin
                    state_next = RD_SI;
                end else begin
                    fcnt_next  = fill_addr;
                    addr_next  = fill_addr;
                    wdata_next = DATA_W'(fill_addr);
                    we_next    = 1'b1;
                end
            end
`endif
            RD_SI: begin
                addr_next  = i;
                state_next = WT_SI;
            end
            WT_SI: begin
                state_next = CAP_SI;
            end
            CAP_SI: begin
                si_next    = ram_rdata[ADDR_W-1:0];
                j_next     = j_sum;
                addr_next  = j_sum;
                state_next = WT_SJ;
            end
            WT_SJ: begin
                state_next = CAP_SJ;
            end
            CAP_SJ: begin
                addr_next  = i;
                wdata_next = DATA_W'(ram_rdata[ADDR_W-1:0]);
                we_next    = 1'b1;
                state_next = WR_J;
            end
            WR_J: begin
                // When i == j both writes carry the same value, so the self-swap needs no special case.
                addr_next  = j;
                wdata_next = DATA_W'(si);
                we_next    = 1'b1;
                if (i == LAST_ADDR) begin
                    state_next = DONE_ST;
                end else begin
                    i_next     = i + ADDR_W'(1);
                    kidx_next  = (kidx == kidx_last) ? '0 : kidx + KIDX_W'(1);
                    state_next = RD_SI;
                end
            end
            DONE_ST: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state == DONE_ST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            i         <= '0;
            j         <= '0;
            kidx      <= '0;
`ifdef RC4_KSA_FILL_EN
            fcnt      <= '0;
`endif
        end else begin
            state     <= state_next;
            busy      <= busy_next;
            done      <= done_next;
            ram_addr  <= addr_next;
            ram_wdata <= wdata_next;
            ram_we    <= we_next;
            i         <= i_next;
            j         <= j_next;
            kidx      <= kidx_next;
`ifdef RC4_KSA_FILL_EN
            fcnt      <= fcnt_next;
`endif
        end
    end

    // NOTE: these hold run data that is always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        key_reg   <= key_next;
        kidx_last <= kidx_last_next;
        si        <= si_next;
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Scoreboard bench for rc4_ksa_engine: a 4-entry instance and a 256-entry instance, each on its own RAM model.
// Expected S-boxes come from a software KSA model or fixed values; honours RC4_KSA_FILL_EN like the design.
module tb_rc4_ksa_engine;

    typedef logic [255:0][7:0] sbox_t;
    typedef logic [31:0][7:0]  kbytes_t;
    typedef struct packed { sbox_t sbox; logic [15:0] lat; logic [15:0] wr; } exp_t;
    typedef struct packed { logic [3:0][1:0] sbox; logic [15:0] lat; logic [15:0] wr; } exp_s_t;
    typedef enum int { M_NORMAL, M_HOLD, M_DISTURB, M_RESET } mode_t;

`ifdef RC4_KSA_FILL_EN
    localparam int         LAT_S = 29;
    localparam int         WR_S  = 12;
    localparam int         LAT_B = 1793;
    localparam int         WR_B  = 768;
    localparam logic [7:0] SCR_B = 8'h5A;
    localparam logic [1:0] SCR_S = 2'b11;
`else
    localparam int         LAT_S = 25;
    localparam int         WR_S  = 8;
    localparam int         LAT_B = 1537;
    localparam int         WR_B  = 512;
    localparam logic [7:0] SCR_B = 8'h00;
    localparam logic [1:0] SCR_S = 2'b00;
`endif

    logic         clk;
    logic         reset_s, start_s, busy_s, done_s, ram_we_s, preload_s;
    logic [7:0]   key_s;
    logic [2:0]   key_len_s;
    logic [1:0]   ram_addr_s, ram_wdata_s, ram_rdata_s;
    logic [1:0]   mem_s [4];

    logic         reset_b, start_b, busy_b, done_b, ram_we_b, preload_b;
    logic [255:0] key_b;
    logic [5:0]   key_len_b;
    logic [7:0]   ram_addr_b, ram_wdata_b, ram_rdata_b;
    logic [7:0]   mem_b [256];

    exp_s_t exp_q_s [$];
    exp_t   exp_q_b [$];
    int     n_pass, n_checks;

    rc4_ksa_engine #(.DATA_W(2), .ADDR_W(2), .MAX_KEY_BYTES(4)) dut_s (
        .clk(clk), .reset(reset_s), .start(start_s), .key(key_s), .key_len(key_len_s),
        .busy(busy_s), .done(done_s), .ram_addr(ram_addr_s), .ram_wdata(ram_wdata_s),
        .ram_we(ram_we_s), .ram_rdata(ram_rdata_s)
    );

    rc4_ksa_engine dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .key(key_b), .key_len(key_len_b),
        .busy(busy_b), .done(done_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_we(ram_we_b), .ram_rdata(ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAMs, read-first; preload writes the starting pattern in one edge.
    always @(posedge clk) begin
        if (preload_s) begin
            for (int k = 0; k < 4; k++) mem_s[k] <= 2'(k) ^ SCR_S;
        end else begin
            if (ram_we_s) mem_s[ram_addr_s] <= ram_wdata_s;
            ram_rdata_s <= mem_s[ram_addr_s];
        end
    end

    always @(posedge clk) begin
        if (preload_b) begin
            for (int k = 0; k < 256; k++) mem_b[k] <= 8'(k) ^ SCR_B;
        end else begin
            if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
            ram_rdata_b <= mem_b[ram_addr_b];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    function automatic sbox_t identity();
        sbox_t s;
        for (int k = 0; k < 256; k++) s[8'(k)] = 8'(k);
        return s;
    endfunction

    function automatic sbox_t ksa_model(input sbox_t init, input kbytes_t kb, input int len);
        sbox_t      s;
        int         j, eff;
        logic [7:0] t;
        s   = init;
        j   = 0;
        eff = (len == 0 || len > 32) ? 32 : len;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s[8'(i)]) + int'(kb[5'(i % eff)])) % 256;
            t = s[8'(i)];
            s[8'(i)] = s[8'(j)];
            s[8'(j)] = t;
        end
        return s;
    endfunction

    function automatic logic [255:0] pack_key(input kbytes_t kb);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[(31-k)*8 +: 8] = kb[5'(k)];
        return v;
    endfunction

    task automatic collect_s(input int budget);
        int     cyc, wr;
        bit     run;
        exp_s_t e;
        run = 0; cyc = 0; wr = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (run) begin
                cyc++;
                if (ram_we_s) wr++;
            end else if (busy_s) begin
                run = 1; cyc = 0; wr = ram_we_s ? 1 : 0;
                start_s = 1'b0;
            end
            if (done_s) begin
                if (exp_q_s.size() == 0) begin
                    check("s_unexpected_done", 1, 0);
                    return;
                end
                e = exp_q_s.pop_front();
                check("s_latency", cyc, e.lat);
                check("s_writes", wr, e.wr);
                for (int k = 0; k < 4; k++) check($sformatf("s_sbox[%0d]", k), mem_s[k], e.sbox[2'(k)]);
                return;
            end
        end
        check("s_timeout", 0, 1);
    endtask

    task automatic run_s(input logic [7:0] key, input logic [2:0] len, input logic [3:0][1:0] want);
        preload_s = 1'b1;
        @(posedge clk); #1;
        preload_s = 1'b0;
        key_s = key; key_len_s = len;
        exp_q_s.push_back('{sbox: want, lat: 16'(LAT_S), wr: 16'(WR_S)});
        start_s = 1'b1;
        collect_s(200);
    endtask

    task automatic collect_b(input mode_t mode, input int budget, output int gap);
        int   cyc, wr;
        bit   run;
        exp_t e;
        run = 0; cyc = 0; wr = 0; gap = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (run) begin
                cyc++;
                if (ram_we_b) wr++;
            end else if (busy_b) begin
                run = 1; cyc = 0; wr = ram_we_b ? 1 : 0;
                if (mode != M_HOLD) start_b = 1'b0;
            end else begin
                gap++;
            end
            if (run && mode == M_DISTURB) begin
                if (cyc == 40) start_b = 1'b1;
                if (cyc == 41) start_b = 1'b0;
                if (cyc == 60) begin
                    key_b = ~key_b;
                    key_len_b = 6'd7;
                end
            end
            if (run && mode == M_RESET && cyc == 100) begin
                reset_b = 1'b1;
                @(negedge clk);
                check("b_abort_busy", busy_b, 0);
                check("b_abort_done", done_b, 0);
                check("b_abort_we", ram_we_b, 0);
                check("b_abort_addr", ram_addr_b, 0);
                check("b_abort_wdata", ram_wdata_b, 0);
                reset_b = 1'b0;
                return;
            end
            if (done_b) begin
                if (exp_q_b.size() == 0) begin
                    check("b_unexpected_done", 1, 0);
                    return;
                end
                e = exp_q_b.pop_front();
                check("b_latency", cyc, e.lat);
                check("b_writes", wr, e.wr);
                for (int k = 0; k < 256; k++) check($sformatf("b_sbox[%0d]", k), mem_b[k], e.sbox[8'(k)]);
                return;
            end
        end
        check("b_timeout", 0, 1);
    endtask

    task automatic run_b(input kbytes_t kb, input logic [5:0] len, input sbox_t want, input mode_t mode);
        int g;
        preload_b = 1'b1;
        @(posedge clk); #1;
        preload_b = 1'b0;
        key_b = pack_key(kb); key_len_b = len;
        if (mode != M_RESET) exp_q_b.push_back('{sbox: want, lat: 16'(LAT_B), wr: 16'(WR_B)});
        start_b = 1'b1;
        collect_b(mode, 3000, g);
    endtask

    initial begin
        kbytes_t kb_key, kb2;
        sbox_t   id, exp1, exp2;
        int      gap;

        n_pass = 0; n_checks = 0;
        reset_s = 1'b1; reset_b = 1'b1; start_s = 1'b0; start_b = 1'b0;
        key_s = '0; key_len_s = '0; key_b = '0; key_len_b = '0;
        preload_s = 1'b0; preload_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("s_rst_busy", busy_s, 0);
        check("s_rst_done", done_s, 0);
        check("s_rst_we", ram_we_s, 0);
        check("s_rst_addr", ram_addr_s, 0);
        check("s_rst_wdata", ram_wdata_s, 0);
        check("b_rst_busy", busy_b, 0);
        check("b_rst_done", done_b, 0);
        check("b_rst_we", ram_we_b, 0);
        check("b_rst_addr", ram_addr_b, 0);
        check("b_rst_wdata", ram_wdata_b, 0);
        reset_s = 1'b0; reset_b = 1'b0;

        // 4-entry S-box; packed values list s[3], s[2], s[1], s[0]; unused key bytes are nonzero.
        run_s({2'd0, 2'd3, 2'd1, 2'd2}, 3'd1, {2'd1, 2'd3, 2'd2, 2'd0});
        run_s({2'd1, 2'd2, 2'd3, 2'd3}, 3'd2, {2'd1, 2'd2, 2'd3, 2'd0});

        for (int k = 0; k < 32; k++) begin
            kb_key[5'(k)] = 8'($urandom);
            kb2[5'(k)]    = 8'($urandom);
        end
        kb_key[0] = 8'h4B; kb_key[1] = 8'h65; kb_key[2] = 8'h79;
        id = identity();

        run_b(kb_key, 6'd3, ksa_model(id, kb_key, 3), M_NORMAL);
        run_b(kb2, 6'd0, ksa_model(id, kb2, 32), M_NORMAL);
        run_b(kb2, 6'd32, ksa_model(id, kb2, 32), M_NORMAL);
        run_b(kb2, 6'd45, ksa_model(id, kb2, 32), M_NORMAL);
        run_b(kb_key, 6'd3, ksa_model(id, kb_key, 3), M_DISTURB);

        // start held high: a second run follows straight after done.
        exp1 = ksa_model(id, kb2, 5);
        run_b(kb2, 6'd5, exp1, M_HOLD);
`ifdef RC4_KSA_FILL_EN
        exp2 = exp1;
`else
        exp2 = ksa_model(exp1, kb2, 5);
`endif
        exp_q_b.push_back('{sbox: exp2, lat: 16'(LAT_B), wr: 16'(WR_B)});
        collect_b(M_NORMAL, 3000, gap);
        check("b_retrigger_gap", gap, 0);

        run_b(kb_key, 6'd3, id, M_RESET);
        run_b(kb_key, 6'd3, ksa_model(id, kb_key, 3), M_NORMAL);

        check("s_queue_empty", exp_q_s.size(), 0);
        check("b_queue_empty", exp_q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
